// File: rtl/mem_stage_hs_pkg.sv
// Shared definitions for the MEM pipeline stage: load-op encodings, default widths
// and the sizing rule for the stale-response discard counter.
package mem_stage_hs_pkg;

    typedef enum logic [2:0] {
        MEM_OP_LW  = 3'd0,
        MEM_OP_LB  = 3'd1,
        MEM_OP_LH  = 3'd2,
        MEM_OP_LBU = 3'd3,
        MEM_OP_LHU = 3'd4
    } mem_op_e;

    localparam int DATA_W_DEF  = 32;
    localparam int PC_W_DEF    = 32;
    localparam int RADDR_W_DEF = 5;

    function automatic int disc_cnt_width(input int max_outst);
        return (max_outst < 1) ? 1 : $clog2(max_outst + 1);
    endfunction

endpackage

// File: rtl/mem_stage_hs_load_align.sv
// Combinational sub-word load alignment: picks the 32-bit lane, then the byte/half
// at the low address bits, and sign- or zero-extends it to the datapath width.
module load_align
    import mem_stage_hs_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [OFF_W-1:0]  off,
    input  logic [2:0]        mem_op,
    output logic [DATA_W-1:0] result
);

    logic [OFF_W-1:0]  lane_base;
    logic [DATA_W-1:0] lane_shifted;
    logic [31:0]       lane;
    logic [7:0]        byte_val;
    logic [15:0]       half_val;

    // Clearing the two byte-offset bits leaves the byte address of the 32-bit lane.
    assign lane_base = off & ~OFF_W'(3);

    always_comb begin
        lane_shifted = rdata >> {lane_base, 3'b000};
        lane         = lane_shifted[31:0];
        case (off[1:0])
            2'd0:    byte_val = lane[7:0];
            2'd1:    byte_val = lane[15:8];
            2'd2:    byte_val = lane[23:16];
            default: byte_val = lane[31:24];
        endcase
        half_val = off[1] ? lane[31:16] : lane[15:0];
        result   = DATA_W'(lane);
        case (mem_op_e'(mem_op))
            MEM_OP_LB:  result = {{(DATA_W - 8){byte_val[7]}}, byte_val};
            MEM_OP_LBU: result = {{(DATA_W - 8){1'b0}}, byte_val};
            MEM_OP_LH:  result = {{(DATA_W - 16){half_val[15]}}, half_val};
            MEM_OP_LHU: result = {{(DATA_W - 16){1'b0}}, half_val};
            default:    ;
        endcase
    end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage between EX and WB: waits for variable-latency data-SRAM responses,
// aligns loads, and discards responses that belong to flushed instructions.
module mem_stage_hs
    import mem_stage_hs_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int PC_W      = PC_W_DEF,
    parameter int RADDR_W   = RADDR_W_DEF,
    parameter int MAX_OUTST = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               es_to_ms_valid,
    output logic               ms_allow_in,
    input  logic [PC_W-1:0]    es_pc,
    input  logic               es_gr_we,
    input  logic [RADDR_W-1:0] es_dest,
    input  logic [DATA_W-1:0]  es_alu_result,
    input  logic               es_res_from_mem,
    input  logic [2:0]         es_mem_op,
    input  logic               es_req_issued,
    input  logic               data_sram_data_ok,
    input  logic [DATA_W-1:0]  data_sram_rdata,
    input  logic               ws_allow_in,
    output logic               ms_to_ws_valid,
    output logic [PC_W-1:0]    ms_pc,
    output logic               ms_gr_we,
    output logic [RADDR_W-1:0] ms_dest,
    output logic [DATA_W-1:0]  ms_final_result,
    output logic               ms_fwd_valid,
    output logic [RADDR_W-1:0] ms_fwd_dest,
    output logic [DATA_W-1:0]  ms_fwd_data,
    output logic               ms_fwd_blocked
);

    localparam int CNT_W = disc_cnt_width(MAX_OUTST);
    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

    logic               ms_valid_q, ms_valid_d;
    logic               wait_rsp_q, wait_rsp_d;
    logic               buf_valid_q, buf_valid_d;
    logic [DATA_W-1:0]  rbuf_q, rbuf_d;
    logic [CNT_W-1:0]   discard_cnt_q, discard_cnt_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               gr_we_q, gr_we_d;
    logic [RADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0]  alu_result_q, alu_result_d;
    logic               res_from_mem_q, res_from_mem_d;
    logic [2:0]         mem_op_q, mem_op_d;

    logic               rsp_live;
    logic               ms_ready_go;
    logic               disc_inc;
    logic               disc_dec;
    logic [DATA_W-1:0]  load_data;
    logic [DATA_W-1:0]  aligned_data;

    // A response only belongs to the instruction in MS once all stale responses are drained.
    assign rsp_live       = data_sram_data_ok & (discard_cnt_q == '0);
    assign ms_ready_go    = !wait_rsp_q | buf_valid_q | rsp_live;
    assign ms_allow_in    = !ms_valid_q | (ms_ready_go & ws_allow_in);
    assign ms_to_ws_valid = ms_valid_q & ms_ready_go & !flush;
    assign disc_inc       = flush & ms_valid_q & wait_rsp_q & !rsp_live;
    assign disc_dec       = data_sram_data_ok & (discard_cnt_q != '0);

    assign load_data = buf_valid_q ? rbuf_q : data_sram_rdata;

    load_align #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_load_align (
        .rdata  (load_data),
        .off    (alu_result_q[OFF_W-1:0]),
        .mem_op (mem_op_q),
        .result (aligned_data)
    );

    assign ms_pc           = pc_q;
    assign ms_gr_we        = gr_we_q;
    assign ms_dest         = dest_q;
    assign ms_final_result = res_from_mem_q ? aligned_data : alu_result_q;
    assign ms_fwd_valid    = ms_valid_q & gr_we_q;
    assign ms_fwd_dest     = dest_q;
    assign ms_fwd_data     = ms_final_result;
    assign ms_fwd_blocked  = ms_valid_q & res_from_mem_q & wait_rsp_q & !rsp_live;

    always_comb begin
        ms_valid_d     = ms_valid_q;
        wait_rsp_d     = wait_rsp_q;
        buf_valid_d    = buf_valid_q;
        rbuf_d         = rbuf_q;
        discard_cnt_d  = discard_cnt_q;
        pc_d           = pc_q;
        gr_we_d        = gr_we_q;
        dest_d         = dest_q;
        alu_result_d   = alu_result_q;
        res_from_mem_d = res_from_mem_q;
        mem_op_d       = mem_op_q;

        // Flush beats both a concurrent accept and a concurrent response capture.
        if (flush) begin
            ms_valid_d  = 1'b0;
            wait_rsp_d  = 1'b0;
            buf_valid_d = 1'b0;
        end else if (ms_allow_in) begin
            ms_valid_d  = es_to_ms_valid;
            wait_rsp_d  = es_to_ms_valid & es_req_issued;
            buf_valid_d = 1'b0;
            if (es_to_ms_valid) begin
                pc_d           = es_pc;
                gr_we_d        = es_gr_we;
                dest_d         = es_dest;
                alu_result_d   = es_alu_result;
                res_from_mem_d = es_res_from_mem;
                mem_op_d       = es_mem_op;
            end
        end else if (ms_valid_q & wait_rsp_q & rsp_live) begin
            rbuf_d      = data_sram_rdata;
            buf_valid_d = 1'b1;
            wait_rsp_d  = 1'b0;
        end

        if (disc_inc & !disc_dec) begin
            discard_cnt_d = discard_cnt_q + CNT_W'(1);
        end else if (disc_dec & !disc_inc) begin
            discard_cnt_d = discard_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid_q     <= 1'b0;
            wait_rsp_q     <= 1'b0;
            buf_valid_q    <= 1'b0;
            rbuf_q         <= '0;
            discard_cnt_q  <= '0;
            pc_q           <= '0;
            gr_we_q        <= 1'b0;
            dest_q         <= '0;
            alu_result_q   <= '0;
            res_from_mem_q <= 1'b0;
            mem_op_q       <= '0;
        end else begin
            ms_valid_q     <= ms_valid_d;
            wait_rsp_q     <= wait_rsp_d;
            buf_valid_q    <= buf_valid_d;
            rbuf_q         <= rbuf_d;
            discard_cnt_q  <= discard_cnt_d;
            pc_q           <= pc_d;
            gr_we_q        <= gr_we_d;
            dest_q         <= dest_d;
            alu_result_q   <= alu_result_d;
            res_from_mem_q <= res_from_mem_d;
            mem_op_q       <= mem_op_d;
        end
    end

    // More flushed requests than the SRAM can have outstanding means the upstream broke its contract.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(disc_inc && !disc_dec && discard_cnt_q == CNT_MAX));
        end
    end

endmodule
